uart_host_bridge: RTL and testbench

//  Host-side bus master that drives the UART controller's CPU port (chip_sel_n / address / read_write /

---
 rtl/uart_host_bridge.sv | 177 +++++++++++++++++
 tb/tb_uart_host_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_host_bridge.sv
// Host bus master for the UART CPU port: one valid/ready request becomes one chip-select strobe.
// Optional define UART_HOST_IRQ_SYNC_EN adds a 2-FF synchroniser on uart_ireq_n_i.
module uart_host_bridge #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned ACK_CYCLES  = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_write_i,
    input  logic [2:0] req_addr_i,
    input  logic [7:0] req_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    input  logic       irq_ack_i,
    output logic       int_pending_o,
    output logic       uart_cs_n_o,
    output logic [2:0] uart_addr_o,
    output logic       uart_rw_o,
    inout  wire  [7:0] uart_data_io,
    output logic       uart_iack_o,
    input  logic       uart_ireq_n_i
);

    localparam int unsigned HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (HG_MAX > ACK_CYCLES) ? HG_MAX : ACK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_e;
    typedef enum logic [1:0] {ACK_IDLE, ACK_PULSE, ACK_REARM} ack_e;

    state_e             state_q, state_d;
    ack_e               ack_state_q, ack_state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic               write_q, write_d;
    logic [2:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               cs_n_q, cs_n_d;
    logic               rw_q, rw_d;
    logic               drive_q, drive_d;
    logic               iack_q, iack_d;
    logic               pend_q, pend_d;
    logic               ireq_n_s;

`ifdef UART_HOST_IRQ_SYNC_EN
    logic [1:0] irq_sync_q, irq_sync_d;

    always_comb irq_sync_d = {irq_sync_q[0], uart_ireq_n_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) irq_sync_q <= '1;
        else          irq_sync_q <= irq_sync_d;
    end

    assign ireq_n_s = irq_sync_q[1];
`else
    assign ireq_n_s = uart_ireq_n_i;
`endif

    // Output registers are computed from the next state so pins line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && ready_q) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(HOLD_CYCLES - 1);
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    if (!write_q) rdata_d = uart_data_io;
                    state_d = RECOVER;
                    cnt_d   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
        endcase

        ready_d     = (state_d == IDLE);
        cs_n_d      = (state_d != STROBE);
        rw_d        = ((state_d == SETUP) || (state_d == STROBE)) ? !write_d : 1'b1;
        drive_d     = write_d && ((state_d == SETUP) || (state_d == STROBE));
        rsp_valid_d = (state_q == STROBE) && (state_d == RECOVER);
    end

    // The forced-low re-arm cycle may itself launch the next pulse if the request is still present.
    always_comb begin
        ack_state_d = ack_state_q;
        ack_cnt_d   = ack_cnt_q;
        case (ack_state_q)
            ACK_PULSE: begin
                if (ack_cnt_q == '0) ack_state_d = ACK_REARM;
                else                 ack_cnt_d   = ack_cnt_q - CNT_W'(1);
            end
            default: begin
                if (irq_ack_i && pend_q) begin
                    ack_state_d = ACK_PULSE;
                    ack_cnt_d   = CNT_W'(ACK_CYCLES - 1);
                end else begin
                    ack_state_d = ACK_IDLE;
                end
            end
        endcase
        iack_d = (ack_state_d == ACK_PULSE);
        pend_d = !ireq_n_s;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            ack_state_q <= ACK_IDLE;
            cnt_q       <= '0;
            ack_cnt_q   <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            rw_q        <= 1'b1;
            drive_q     <= 1'b0;
            iack_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_state_q <= ack_state_d;
            cnt_q       <= cnt_d;
            ack_cnt_q   <= ack_cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            cs_n_q      <= cs_n_d;
            rw_q        <= rw_d;
            drive_q     <= drive_d;
            iack_q      <= iack_d;
            pend_q      <= pend_d;
        end
    end

    assign uart_data_io  = drive_q ? wdata_q : 'z;
    assign req_ready_o   = ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign uart_cs_n_o   = cs_n_q;
    assign uart_addr_o   = addr_q;
    assign uart_rw_o     = rw_q;
    assign uart_iack_o   = iack_q;
    assign int_pending_o = pend_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Directed bench for uart_host_bridge: bus timing, read return, back-to-back, irq ack, reset abort.
module tb_uart_host_bridge;

`ifdef UART_HOST_IRQ_SYNC_EN
    localparam int LAG = 3;
`else
    localparam int LAG = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_write;
    logic [2:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       irq_ack, int_pending;
    logic       cs_n, uart_rw, uart_iack, ireq_n;
    logic [2:0] uart_addr;
    logic [7:0] model_rdata;
    wire  [7:0] data_bus;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;
    int e0;

    always #5 clk = ~clk;

    // UART model: drives read data while selected for a read; bus idles high otherwise.
    assign data_bus = (!cs_n && uart_rw) ? model_rdata : 'z;
    pullup (data_bus);

    always @(negedge cs_n) edges++;

    uart_host_bridge #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .ACK_CYCLES(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
        .irq_ack_i(irq_ack), .int_pending_o(int_pending),
        .uart_cs_n_o(cs_n), .uart_addr_o(uart_addr), .uart_rw_o(uart_rw),
        .uart_data_io(data_bus), .uart_iack_o(uart_iack), .uart_ireq_n_i(ireq_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic e_cs, input logic e_rw,
                           input logic [2:0] e_addr, input logic [7:0] e_data, input logic e_rv);
        check({tag, "_cs_n"}, {7'd0, cs_n}, {7'd0, e_cs});
        check({tag, "_rw"}, {7'd0, uart_rw}, {7'd0, e_rw});
        check({tag, "_addr"}, {5'd0, uart_addr}, {5'd0, e_addr});
        check({tag, "_data"}, data_bus, e_data);
        check({tag, "_rsp_valid"}, {7'd0, rsp_valid}, {7'd0, e_rv});
    endtask

    function automatic logic exp_iack(input int k);
        int j, start;
        if (k < LAG + 1) return 1'b0;
        j     = k - (LAG + 1);
        start = LAG + 1 + 3 * (j / 3);
        return ((j % 3) < 2) && (start - 1 <= 9);
    endfunction

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        irq_ack = 1'b0; ireq_n = 1'b1; model_rdata = 8'h3C;
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", {7'd0, req_ready}, 8'h01);
        check("rst_rdata", rsp_rdata, 8'h00);
        check("rst_iack", {7'd0, uart_iack}, 8'h00);
        check("rst_pend", {7'd0, int_pending}, 8'h00);
        chk_bus("rst", 1'b1, 1'b1, 3'd0, 8'hFF, 1'b0);
        step; step;
        rst_n = 1'b1;
        step;

        // Write addr 3 data A5
        e0 = edges;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd3; req_wdata = 8'hA5;
        step; req_valid = 1'b0;
        check("wr_ready_low", {7'd0, req_ready}, 8'h00);
        chk_bus("wr_setup", 1'b1, 1'b0, 3'd3, 8'hA5, 1'b0);
        step; chk_bus("wr_strobe1", 1'b0, 1'b0, 3'd3, 8'hA5, 1'b0);
        step; chk_bus("wr_strobe2", 1'b0, 1'b0, 3'd3, 8'hA5, 1'b0);
        step; chk_bus("wr_recover", 1'b1, 1'b1, 3'd3, 8'hFF, 1'b1);
        step;
        check("wr_rsp_end", {7'd0, rsp_valid}, 8'h00);
        check("wr_ready_back", {7'd0, req_ready}, 8'h01);
        check("wr_edges", 8'(edges - e0), 8'd1);

        // Read addr 5, UART returns 3C
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd5; req_wdata = 8'h00;
        step; req_valid = 1'b0;
        chk_bus("rd_setup", 1'b1, 1'b1, 3'd5, 8'hFF, 1'b0);
        step; chk_bus("rd_strobe1", 1'b0, 1'b1, 3'd5, 8'h3C, 1'b0);
        step; chk_bus("rd_strobe2", 1'b0, 1'b1, 3'd5, 8'h3C, 1'b0);
        step; chk_bus("rd_recover", 1'b1, 1'b1, 3'd5, 8'hFF, 1'b1);
        check("rd_rdata", rsp_rdata, 8'h3C);
        step;
        check("rd_rsp_end", {7'd0, rsp_valid}, 8'h00);
        check("rd_rdata_hold", rsp_rdata, 8'h3C);

        // Back-to-back writes with valid held
        e0 = edges;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd1; req_wdata = 8'h11;
        step;
        chk_bus("b2b_setup1", 1'b1, 1'b0, 3'd1, 8'h11, 1'b0);
        req_addr = 3'd2; req_wdata = 8'h22;
        step; chk_bus("b2b_strobe1a", 1'b0, 1'b0, 3'd1, 8'h11, 1'b0);
        step; chk_bus("b2b_strobe1b", 1'b0, 1'b0, 3'd1, 8'h11, 1'b0);
        step;
        chk_bus("b2b_recover1", 1'b1, 1'b1, 3'd1, 8'hFF, 1'b1);
        check("b2b_ready_n4", {7'd0, req_ready}, 8'h00);
        step;
        check("b2b_ready_n5", {7'd0, req_ready}, 8'h01);
        check("b2b_gap_cs", {7'd0, cs_n}, 8'h01);
        step; req_valid = 1'b0;
        check("b2b_ready_n6", {7'd0, req_ready}, 8'h00);
        chk_bus("b2b_setup2", 1'b1, 1'b0, 3'd2, 8'h22, 1'b0);
        step; chk_bus("b2b_strobe2a", 1'b0, 1'b0, 3'd2, 8'h22, 1'b0);
        step; chk_bus("b2b_strobe2b", 1'b0, 1'b0, 3'd2, 8'h22, 1'b0);
        step; chk_bus("b2b_recover2", 1'b1, 1'b1, 3'd2, 8'hFF, 1'b1);
        step;
        check("b2b_edges", 8'(edges - e0), 8'd2);

        // Interrupt pending with level ack held 10 cycles
        ireq_n = 1'b0; irq_ack = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 10) irq_ack = 1'b0;
            check($sformatf("irq_pend_%0d", k), {7'd0, int_pending}, {7'd0, k >= LAG});
            check($sformatf("irq_iack_%0d", k), {7'd0, uart_iack}, {7'd0, exp_iack(k)});
            step;
        end
        ireq_n = 1'b1;
        repeat (6) step;
        check("irq_pend_clear", {7'd0, int_pending}, 8'h00);

        // Interrupt released after first pulse is launched: no second pulse
        ireq_n = 1'b0; irq_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == LAG) ireq_n = 1'b1;
            check($sformatf("rel_iack_%0d", k), {7'd0, uart_iack},
                  {7'd0, (k == LAG + 1) || (k == LAG + 2)});
            step;
        end
        check("rel_pend_low", {7'd0, int_pending}, 8'h00);

        // Ack request with nothing pending during a write
        irq_ack = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd6; req_wdata = 8'h5A;
        step; req_valid = 1'b0;
        check("noirq_iack1", {7'd0, uart_iack}, 8'h00);
        step;
        chk_bus("noirq_strobe", 1'b0, 1'b0, 3'd6, 8'h5A, 1'b0);
        check("noirq_iack2", {7'd0, uart_iack}, 8'h00);
        step;
        check("noirq_iack3", {7'd0, uart_iack}, 8'h00);
        step;
        chk_bus("noirq_recover", 1'b1, 1'b1, 3'd6, 8'hFF, 1'b1);
        check("noirq_iack4", {7'd0, uart_iack}, 8'h00);
        irq_ack = 1'b0;
        step;

        // Reset asserted during a write strobe with an ack pulse in flight
        ireq_n = 1'b0; irq_ack = 1'b1;
        repeat (LAG) step;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 3'd7; req_wdata = 8'hC3;
        step; req_valid = 1'b0;
        check("rst_pre_iack1", {7'd0, uart_iack}, 8'h01);
        step;
        chk_bus("rst_pre_strobe", 1'b0, 1'b0, 3'd7, 8'hC3, 1'b0);
        check("rst_pre_iack2", {7'd0, uart_iack}, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", {7'd0, cs_n}, 8'h01);
        check("rst_mid_data", data_bus, 8'hFF);
        check("rst_mid_iack", {7'd0, uart_iack}, 8'h00);
        check("rst_mid_rsp", {7'd0, rsp_valid}, 8'h00);
        ireq_n = 1'b1; irq_ack = 1'b0;
        step; rst_n = 1'b1;
        check("rst_rel_ready", {7'd0, req_ready}, 8'h01);
        step; check("rst_rel_rsp1", {7'd0, rsp_valid}, 8'h00);
        step; check("rst_rel_rsp2", {7'd0, rsp_valid}, 8'h00);

        // Fresh read after reset
        model_rdata = 8'h96;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd4;
        step; req_valid = 1'b0;
        chk_bus("post_setup", 1'b1, 1'b1, 3'd4, 8'hFF, 1'b0);
        step; chk_bus("post_strobe", 1'b0, 1'b1, 3'd4, 8'h96, 1'b0);
        step; step;
        chk_bus("post_recover", 1'b1, 1'b1, 3'd4, 8'hFF, 1'b1);
        check("post_rdata", rsp_rdata, 8'h96);
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
